// File: rtl/pattern_chk_pkg.sv
// Shared definitions for the DDR read-back pattern checker: marker defaults,
// error-class codes (decoded by the downstream error switch) and FSM states.
package pattern_chk_pkg;

    localparam logic [15:0] EVT_MARKER_DEF  = 16'hE7E7;
    localparam logic [15:0] HDR1_MARKER_DEF = 16'h0001;

    // err_en class codes; must stay aligned with the switch's decode
    localparam logic [1:0] ERR_EVT  = 2'b00;
    localparam logic [1:0] ERR_HDR1 = 2'b01;
    localparam logic [1:0] ERR_HDR2 = 2'b10;
    localparam logic [1:0] ERR_DATA = 2'b11;

    typedef enum logic [1:0] {
        S_EVT  = 2'd0,
        S_HDR1 = 2'd1,
        S_HDR2 = 2'd2,
        S_DATA = 2'd3
    } chk_state_e;

    // Word class being checked in a given FSM state
    function automatic logic [1:0] state_cls(input chk_state_e s);
        logic [1:0] c;
        c = ERR_DATA;
        case (s)
            S_EVT:   c = ERR_EVT;
            S_HDR1:  c = ERR_HDR1;
            S_HDR2:  c = ERR_HDR2;
            default: c = ERR_DATA;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pattern_checker_gen.sv
// Expected-word generator: maps (tag, nwords, state, data index) to the
// 64-bit word the stream should carry at that position. Purely combinational.
module pattern_gen
    import pattern_chk_pkg::*;
#(
    parameter logic [15:0] EVT_MARKER  = EVT_MARKER_DEF,
    parameter logic [15:0] HDR1_MARKER = HDR1_MARKER_DEF
) (
    input  logic [47:0] tag,
    input  logic [31:0] nwords,
    input  chk_state_e  state,
    input  logic [31:0] idx,
    output logic [63:0] exp_word
);

    logic [63:0] evt_word;

    // Select the expected word for the current stream position
    always_comb begin
        evt_word = {EVT_MARKER, tag};
        exp_word = evt_word;
        case (state)
            S_EVT:   exp_word = evt_word;
            S_HDR1:  exp_word = {HDR1_MARKER, 16'h0000, nwords};
            S_HDR2:  exp_word = ~evt_word;
            default: exp_word = {tag[31:0], idx};
        endcase
    end

endmodule

// File: rtl/pattern_checker.sv
// DDR read-back pattern checker. Walks EVT/HDR1/HDR2/DATA positions of each
// event, compares against pattern_gen, and records the first mismatch per
// class, the first failing class, a sticky flag and saturating counters.
// Optional: PATTERN_CHK_RESYNC_EN reloads the tag from a mismatching event
// word that still carries the event marker.
module pattern_checker
    import pattern_chk_pkg::*;
#(
    parameter logic [15:0] EVT_MARKER  = EVT_MARKER_DEF,
    parameter logic [15:0] HDR1_MARKER = HDR1_MARKER_DEF,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             err_clr,
    input  logic [47:0]      start_tag,
    input  logic [31:0]      nwords,
    input  logic [63:0]      din,
    input  logic             din_valid,
    output logic [1:0]       err_en,
    output logic             err_flag,
    output logic [63:0]      evt_expc,
    output logic [63:0]      evt_seen,
    output logic [63:0]      hdr1_expc,
    output logic [63:0]      hdr1_seen,
    output logic [63:0]      hdr2_expc,
    output logic [63:0]      hdr2_seen,
    output logic [63:0]      data_expc,
    output logic [63:0]      data_seen,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Sequencing state
    chk_state_e  state_q, state_d;
    logic [47:0] tag_q, tag_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] nwords_q, nwords_d;

    // Registered compare stage
    logic        cmp_vld_q, cmp_vld_d;
    logic [1:0]  cmp_cls_q, cmp_cls_d;
    logic [63:0] cmp_exp_q, cmp_exp_d;
    logic [63:0] cmp_seen_q, cmp_seen_d;

    // Error bookkeeping, latches indexed by class code
    logic             err_flag_q, err_flag_d;
    logic [1:0]       err_en_q, err_en_d;
    logic [3:0]       cls_hit_q, cls_hit_d;
    logic [3:0][63:0] exp_lat_q, exp_lat_d;
    logic [3:0][63:0] seen_lat_q, seen_lat_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

    logic [63:0] exp_word;
    logic        accept;
    logic        mism;
    logic        event_done;

    pattern_gen #(
        .EVT_MARKER  (EVT_MARKER),
        .HDR1_MARKER (HDR1_MARKER)
    ) u_gen (
        .tag      (tag_q),
        .nwords   (nwords),
        .state    (state_q),
        .idx      (idx_q),
        .exp_word (exp_word)
    );

    // Step through word positions; a mismatch never alters sequencing
    always_comb begin
        accept     = din_valid && chk_en;
        mism       = accept && (exp_word != din);
        event_done = 1'b0;
        state_d    = state_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        nwords_d   = nwords_q;
        if (!chk_en) begin
            // Partial event abandoned; tag kept, nothing counted
            state_d = S_EVT;
            idx_d   = '0;
        end else if (din_valid) begin
            case (state_q)
                S_EVT: begin
                    state_d = S_HDR1;
`ifdef PATTERN_CHK_RESYNC_EN
                    // Follow a stream that skipped ahead so one dropped event costs one error
                    if (mism && (din[63:48] == EVT_MARKER))
                        tag_d = din[47:0];
`endif
                end
                S_HDR1: begin
                    nwords_d = nwords;
                    state_d  = S_HDR2;
                end
                S_HDR2: begin
                    idx_d = '0;
                    if (nwords_q != '0) begin
                        state_d = S_DATA;
                    end else begin
                        event_done = 1'b1;
                        state_d    = S_EVT;
                    end
                end
                default: begin
                    if (idx_q == nwords_q - 32'd1) begin
                        event_done = 1'b1;
                        state_d    = S_EVT;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + 32'd1;
                    end
                end
            endcase
        end
        if (event_done)
            tag_d = tag_q + 48'd1;
    end

    // Capture the compare result for the next-cycle bookkeeping
    always_comb begin
        cmp_vld_d  = mism;
        cmp_cls_d  = state_cls(state_q);
        cmp_exp_d  = exp_word;
        cmp_seen_d = din;
    end

    // Update first-mismatch latches, sticky flag and saturating counters
    always_comb begin
        err_flag_d = err_flag_q;
        err_en_d   = err_en_q;
        cls_hit_d  = cls_hit_q;
        exp_lat_d  = exp_lat_q;
        seen_lat_d = seen_lat_q;
        err_cnt_d  = err_cnt_q;
        evt_cnt_d  = evt_cnt_q;
        if (cmp_vld_q) begin
            err_flag_d = 1'b1;
            if (!err_flag_q)
                err_en_d = cmp_cls_q;
            if (!cls_hit_q[cmp_cls_q]) begin
                cls_hit_d[cmp_cls_q]  = 1'b1;
                exp_lat_d[cmp_cls_q]  = cmp_exp_q;
                seen_lat_d[cmp_cls_q] = cmp_seen_q;
            end
            if (err_cnt_q != CNT_MAX)
                err_cnt_d = err_cnt_q + 1'b1;
        end
        if (event_done && (evt_cnt_q != CNT_MAX))
            evt_cnt_d = evt_cnt_q + 1'b1;
    end

    // State registers; err_clr behaves like reset and drops any in-flight compare
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            state_q    <= S_EVT;
            tag_q      <= start_tag;
            idx_q      <= '0;
            nwords_q   <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_cls_q  <= '0;
            cmp_exp_q  <= '0;
            cmp_seen_q <= '0;
            err_flag_q <= 1'b0;
            err_en_q   <= '0;
            cls_hit_q  <= '0;
            exp_lat_q  <= '0;
            seen_lat_q <= '0;
            err_cnt_q  <= '0;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            nwords_q   <= nwords_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_cls_q  <= cmp_cls_d;
            cmp_exp_q  <= cmp_exp_d;
            cmp_seen_q <= cmp_seen_d;
            err_flag_q <= err_flag_d;
            err_en_q   <= err_en_d;
            cls_hit_q  <= cls_hit_d;
            exp_lat_q  <= exp_lat_d;
            seen_lat_q <= seen_lat_d;
            err_cnt_q  <= err_cnt_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign err_en    = err_en_q;
    assign err_flag  = err_flag_q;
    assign evt_expc  = exp_lat_q[ERR_EVT];
    assign evt_seen  = seen_lat_q[ERR_EVT];
    assign hdr1_expc = exp_lat_q[ERR_HDR1];
    assign hdr1_seen = seen_lat_q[ERR_HDR1];
    assign hdr2_expc = exp_lat_q[ERR_HDR2];
    assign hdr2_seen = seen_lat_q[ERR_HDR2];
    assign data_expc = exp_lat_q[ERR_DATA];
    assign data_seen = seen_lat_q[ERR_DATA];
    assign err_cnt   = err_cnt_q;
    assign evt_cnt   = evt_cnt_q;

endmodule

// File: tb/tb_pattern_checker.sv
// Directed bench for pattern_checker. A second instance with 2-bit counters
// shares the stimulus so counter saturation is reached in a few events.
module tb_pattern_checker;

    logic        clk = 1'b0;
    logic        reset, chk_en, err_clr, din_valid;
    logic [47:0] start_tag;
    logic [31:0] nwords;
    logic [63:0] din;

    logic [1:0]  err_en;
    logic        err_flag;
    logic [63:0] evt_expc, evt_seen, hdr1_expc, hdr1_seen;
    logic [63:0] hdr2_expc, hdr2_seen, data_expc, data_seen;
    logic [15:0] err_cnt, evt_cnt;

    logic [1:0]  s_err_en;
    logic        s_err_flag;
    logic [63:0] s_evt_expc, s_evt_seen, s_hdr1_expc, s_hdr1_seen;
    logic [63:0] s_hdr2_expc, s_hdr2_seen, s_data_expc, s_data_seen;
    logic [1:0]  s_err_cnt, s_evt_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pattern_checker dut (
        .clk(clk), .reset(reset), .chk_en(chk_en), .err_clr(err_clr),
        .start_tag(start_tag), .nwords(nwords), .din(din), .din_valid(din_valid),
        .err_en(err_en), .err_flag(err_flag),
        .evt_expc(evt_expc), .evt_seen(evt_seen),
        .hdr1_expc(hdr1_expc), .hdr1_seen(hdr1_seen),
        .hdr2_expc(hdr2_expc), .hdr2_seen(hdr2_seen),
        .data_expc(data_expc), .data_seen(data_seen),
        .err_cnt(err_cnt), .evt_cnt(evt_cnt)
    );

    pattern_checker #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .chk_en(chk_en), .err_clr(err_clr),
        .start_tag(start_tag), .nwords(nwords), .din(din), .din_valid(din_valid),
        .err_en(s_err_en), .err_flag(s_err_flag),
        .evt_expc(s_evt_expc), .evt_seen(s_evt_seen),
        .hdr1_expc(s_hdr1_expc), .hdr1_seen(s_hdr1_seen),
        .hdr2_expc(s_hdr2_expc), .hdr2_seen(s_hdr2_seen),
        .data_expc(s_data_expc), .data_seen(s_data_seen),
        .err_cnt(s_err_cnt), .evt_cnt(s_evt_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] w);
        @(negedge clk);
        din       = w;
        din_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        din_valid = 1'b0;
        err_clr   = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
    endtask

    // Positions: 0 evt, 1 hdr1, 2 hdr2, 3.. data; masked positions carry bad_val
    task automatic send_event(input logic [47:0] t, input logic [31:0] nw,
                              input logic [7:0] bad_mask, input logic [63:0] bad_val);
        logic [63:0] w;
        logic [63:0] ev;
        int n;
        n  = int'(nw);
        ev = {16'hE7E7, t};
        for (int p = 0; p < 3 + n; p++) begin
            case (p)
                0:       w = ev;
                1:       w = {16'h0001, 16'h0000, nw};
                2:       w = ~ev;
                default: w = {t[31:0], 32'(p - 3)};
            endcase
            if (p < 8 && bad_mask[p]) w = bad_val;
            drive(w);
        end
    endtask

    initial begin
        reset = 1'b1; chk_en = 1'b1; err_clr = 1'b0; din_valid = 1'b0;
        din = '0; start_tag = 48'h10; nwords = 32'd2;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_err_flag", 64'(err_flag), 64'd0);
        chk("rst_err_en",   64'(err_en),   64'd0);
        chk("rst_err_cnt",  64'(err_cnt),  64'd0);
        chk("rst_evt_cnt",  64'(evt_cnt),  64'd0);
        chk("rst_data_expc", data_expc, 64'd0);

        // Clean event, then tag 0x11 must be expected next
        send_event(48'h10, 32'd2, 8'h00, 64'd0);
        idle(2);
        chk("clean_err_flag", 64'(err_flag), 64'd0);
        chk("clean_evt_cnt",  64'(evt_cnt),  64'd1);
        send_event(48'h11, 32'd2, 8'h00, 64'd0);
        idle(2);
        chk("next_tag_err_cnt", 64'(err_cnt), 64'd0);
        chk("next_tag_evt_cnt", 64'(evt_cnt), 64'd2);

        // Data word 1 corrupted
        pulse_clr();
        chk("clr_evt_cnt", 64'(evt_cnt), 64'd0);
        send_event(48'h10, 32'd2, 8'h10, 64'hDEAD);
        idle(2);
        chk("d1_err_en",    64'(err_en), 64'd3);
        chk("d1_data_expc", data_expc,   64'h0000_0010_0000_0001);
        chk("d1_data_seen", data_seen,   64'h0000_0000_0000_DEAD);
        chk("d1_err_cnt",   64'(err_cnt), 64'd1);
        chk("d1_evt_expc",  evt_expc,    64'd0);
        chk("d1_hdr1_seen", hdr1_seen,   64'd0);
        chk("d1_hdr2_expc", hdr2_expc,   64'd0);

        // Bad hdr1 then bad data: first class stays hdr1
        pulse_clr();
        send_event(48'h10, 32'd2, 8'h02, 64'h0001_0000_0000_0003);
        send_event(48'h11, 32'd2, 8'h08, 64'h1234);
        idle(2);
        chk("h1d_err_en",    64'(err_en), 64'd1);
        chk("h1d_hdr1_expc", hdr1_expc,   64'h0001_0000_0000_0002);
        chk("h1d_hdr1_seen", hdr1_seen,   64'h0001_0000_0000_0003);
        chk("h1d_data_expc", data_expc,   64'h0000_0011_0000_0000);
        chk("h1d_data_seen", data_seen,   64'h0000_0000_0000_1234);
        chk("h1d_err_cnt",   64'(err_cnt), 64'd2);
        chk("h1d_evt_cnt",   64'(evt_cnt), 64'd2);

        // nwords = 0: three-word events
        pulse_clr();
        nwords = 32'd0;
        send_event(48'h10, 32'd0, 8'h00, 64'd0);
        send_event(48'h11, 32'd0, 8'h00, 64'd0);
        send_event(48'h12, 32'd0, 8'h00, 64'd0);
        idle(2);
        chk("nw0_evt_cnt", 64'(evt_cnt), 64'd3);
        chk("nw0_err_cnt", 64'(err_cnt), 64'd0);

        // err_clr while a hdr1 mismatch is in flight: discarded
        drive({16'hE7E7, 48'h13});
        drive(64'hBAD);
        pulse_clr();
        chk("midclr_err_flag",  64'(err_flag), 64'd0);
        chk("midclr_err_cnt",   64'(err_cnt),  64'd0);
        chk("midclr_evt_cnt",   64'(evt_cnt),  64'd0);
        chk("midclr_hdr1_seen", hdr1_seen,     64'd0);
        send_event(48'h10, 32'd0, 8'h00, 64'd0);
        idle(2);
        chk("midclr_tag_err_cnt", 64'(err_cnt), 64'd0);
        chk("midclr_tag_evt_cnt", 64'(evt_cnt), 64'd1);

        // chk_en drop mid-event: FSM back to S_EVT, tag kept, not counted
        pulse_clr();
        nwords = 32'd2;
        drive({16'hE7E7, 48'h10});
        drive(64'h0001_0000_0000_0002);
        @(negedge clk);
        din_valid = 1'b0;
        chk_en    = 1'b0;
        @(negedge clk);
        chk_en    = 1'b1;
        send_event(48'h10, 32'd2, 8'h00, 64'd0);
        idle(2);
        chk("chken_err_cnt", 64'(err_cnt), 64'd0);
        chk("chken_evt_cnt", 64'(evt_cnt), 64'd1);

        // Reset mid-event
        drive({16'hE7E7, 48'h11});
        @(negedge clk);
        din_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        send_event(48'h10, 32'd2, 8'h00, 64'd0);
        idle(2);
        chk("rstmid_err_cnt", 64'(err_cnt), 64'd0);
        chk("rstmid_evt_cnt", 64'(evt_cnt), 64'd1);

        // Skipped event: tag 0x12 arrives while 0x11 expected
        pulse_clr();
        send_event(48'h10, 32'd2, 8'h00, 64'd0);
        send_event(48'h12, 32'd2, 8'h00, 64'd0);
        send_event(48'h13, 32'd2, 8'h00, 64'd0);
        idle(2);
        chk("skip_err_en",   64'(err_en), 64'd0);
        chk("skip_evt_expc", evt_expc,    64'hE7E7_0000_0000_0011);
        chk("skip_evt_seen", evt_seen,    64'hE7E7_0000_0000_0012);
        chk("skip_evt_cnt",  64'(evt_cnt), 64'd3);
`ifdef PATTERN_CHK_RESYNC_EN
        chk("skip_err_cnt",  64'(err_cnt), 64'd1);
`else
        chk("skip_err_cnt",  64'(err_cnt), 64'd8);
`endif

        // Saturation on the 2-bit instance; later same-class errors keep first latch
        pulse_clr();
        send_event(48'h10, 32'd2, 8'h1E, 64'd0);
        send_event(48'h11, 32'd2, 8'h1E, 64'd0);
        idle(2);
        chk("sat_err_cnt",   64'(err_cnt),   64'd8);
        chk("sat_s_err_cnt", 64'(s_err_cnt), 64'd3);
        chk("sat_data_expc", data_expc,      64'h0000_0010_0000_0000);
        chk("sat_hdr1_expc", hdr1_expc,      64'h0001_0000_0000_0002);
        chk("sat_err_en",    64'(err_en),    64'd1);
        send_event(48'h12, 32'd2, 8'h00, 64'd0);
        send_event(48'h13, 32'd2, 8'h00, 64'd0);
        idle(2);
        chk("sat_evt_cnt",   64'(evt_cnt),   64'd4);
        chk("sat_s_evt_cnt", 64'(s_evt_cnt), 64'd3);
        chk("sat_s_err_hold", 64'(s_err_cnt), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
